// File: rtl/eval_pkg.sv
// Shared types and width helpers for the evaluation sequencer.
package eval_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FP_LAUNCH,
    FP_WAIT,
    READ,
    DRAIN,
    DONE
  } state_t;

  // Pipeline depth behind the last read strobe (RAM latency + S1 + S2 feeding S3).
  localparam int DRAIN_CYCLES = 3;
  localparam int DRAIN_W      = 2;

  // Width of the sign-extended difference of two DATA_W words.
  function automatic int diff_w(input int data_w);
    return data_w + 1;
  endfunction

  // Width of the squared difference; one spare bit keeps the signed product non-negative.
  function automatic int sq_w(input int data_w);
    return 2 * data_w + 2;
  endfunction

endpackage

// File: rtl/sq_err_pipe.sv
// Two-stage squared-error pipe: S1 difference, S2 square, with valid alongside.
module sq_err_pipe
  import eval_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int SQ_W   = sq_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_p0,
  input  logic [DATA_W-1:0] actual,
  input  logic [DATA_W-1:0] pred,
  output logic              vld_p2,
  output logic [SQ_W-1:0]   sq_p2
);

  localparam int DIFF_W = diff_w(DATA_W);

  logic signed [DIFF_W-1:0] act_ext;
  logic signed [DIFF_W-1:0] pred_ext;
  logic signed [DIFF_W-1:0] diff_p1;
  logic signed [SQ_W-1:0]   diff_wide;
  logic signed [SQ_W-1:0]   prod;
  logic                     vld_p1;

  assign act_ext  = {actual[DATA_W-1], actual};
  assign pred_ext = {pred[DATA_W-1], pred};

  // ---- S1: difference (one extra bit, cannot overflow)
  // Capture the difference only for real samples.
  always_ff @(posedge clk) begin
    if (vld_p0) diff_p1 <= act_ext - pred_ext;
  end

  assign diff_wide = {{(SQ_W - DIFF_W){diff_p1[DIFF_W-1]}}, diff_p1};
  assign prod      = diff_wide * diff_wide;

  // ---- S2: square, always non-negative so stored unsigned
  // Capture the square only behind a valid difference.
  always_ff @(posedge clk) begin
    if (vld_p1) sq_p2 <= prod;
  end

  // Valid bits follow the data through both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

endmodule

// File: rtl/eval_ctrl.sv
// Evaluation-pass sequencer: launches forward propagation, walks the
// result/label RAM and accumulates a saturating sum of squared errors.
module eval_ctrl
  import eval_pkg::*;
#(
  parameter int ROWS   = 100,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              fp_start,
  input  logic              fp_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] actual,
  input  logic [DATA_W-1:0] pred,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sse,
  output logic              overflow
);

  localparam int SQ_W = sq_w(DATA_W);

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               start_acc;
  logic               vld_p0;
  logic               vld_p2;
  logic [SQ_W-1:0]    sq_p2;
  logic [ACC_W:0]     acc_next;

  // Saturating add; the top bit of the result flags that the clamp engaged.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [SQ_W-1:0]  sq);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {1'b0, ACC_W'(sq)};
    if (sum[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
    return sum;
  endfunction

  // A start is only honoured while idle or holding a result.
  assign start_acc = start && ((state == IDLE) || (state == DONE));

  // Sequencer with registered strobes, address counter and drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fp_start  <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_acc) begin
            state    <= FP_LAUNCH;
            fp_start <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            rd_addr  <= '0;
          end
        end
        FP_LAUNCH: begin
          fp_start <= 1'b0;
          state    <= FP_WAIT;
        end
        FP_WAIT: begin
          if (fp_done) begin
            state   <= READ;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end
        READ: begin
          if (rd_addr == ADDR_W'(ROWS - 1)) begin
            rd_en     <= 1'b0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          fp_start <= 1'b0;
          rd_en    <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // ---- P0: RAM word arrives one cycle after the read strobe
  // Read-data valid is the strobe delayed by the RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= rd_en;
  end

  sq_err_pipe #(
    .DATA_W (DATA_W)
  ) u_sq_err_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_p0 (vld_p0),
    .actual (actual),
    .pred   (pred),
    .vld_p2 (vld_p2),
    .sq_p2  (sq_p2)
  );

  // ---- S3: saturating accumulate
  assign acc_next = sat_add(sse, sq_p2);

  // Accumulator and sticky overflow; cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sse      <= '0;
      overflow <= 1'b0;
    end else if (start_acc) begin
      sse      <= '0;
      overflow <= 1'b0;
    end else if (vld_p2) begin
      sse <= acc_next[ACC_W-1:0];
      if (acc_next[ACC_W]) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eval_ctrl.sv
// Directed bench for eval_ctrl: one 4-row 16-bit instance, one 8-row 8-bit
// instance with a narrow accumulator for saturation.
module tb_eval_ctrl;

  localparam int A_ROWS = 4;
  localparam int B_ROWS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: ROWS=4, DATA_W=16, ACC_W=40
  logic        start_a = 1'b0, fp_done_a = 1'b0;
  logic        fp_start_a, rd_en_a, busy_a, done_a, ovf_a;
  logic [2:0]  rd_addr_a;
  logic [15:0] act_a, pred_a;
  logic [39:0] sse_a;
  logic [15:0] mem_act_a [0:7];
  logic [15:0] mem_pred_a[0:7];

  // Instance B: ROWS=8, DATA_W=8, ACC_W=18
  logic        start_b = 1'b0, fp_done_b = 1'b0;
  logic        fp_start_b, rd_en_b, busy_b, done_b, ovf_b;
  logic [2:0]  rd_addr_b;
  logic [7:0]  act_b, pred_b;
  logic [17:0] sse_b;
  logic [7:0]  mem_act_b [0:7];
  logic [7:0]  mem_pred_b[0:7];

  int checks = 0;
  int failures = 0;
  int fp_cnt_a = 0;
  int addr_q[$];
  int n;

  eval_ctrl #(.ROWS(A_ROWS), .ADDR_W(3), .DATA_W(16), .ACC_W(40)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .fp_start(fp_start_a),
    .fp_done(fp_done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .actual(act_a), .pred(pred_a), .busy(busy_a), .done(done_a),
    .sse(sse_a), .overflow(ovf_a)
  );

  eval_ctrl #(.ROWS(B_ROWS), .ADDR_W(3), .DATA_W(8), .ACC_W(18)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .fp_start(fp_start_b),
    .fp_done(fp_done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .actual(act_b), .pred(pred_b), .busy(busy_b), .done(done_b),
    .sse(sse_b), .overflow(ovf_b)
  );

  // One-cycle-latency RAM models
  always_ff @(posedge clk) begin
    if (rd_en_a) begin
      act_a  <= mem_act_a[rd_addr_a];
      pred_a <= mem_pred_a[rd_addr_a];
    end
    if (rd_en_b) begin
      act_b  <= mem_act_b[rd_addr_b];
      pred_b <= mem_pred_b[rd_addr_b];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_a(input int idx, input int act, input int prd);
    mem_act_a[idx]  = 16'(act);
    mem_pred_a[idx] = 16'(prd);
  endtask

  // Advance to the next falling edge and record A's strobes.
  task automatic tick_a();
    @(negedge clk);
    if (rd_en_a) addr_q.push_back(int'(rd_addr_a));
    if (fp_start_a) fp_cnt_a++;
  endtask

  task automatic start_pulse_a(input logic with_fp_done);
    start_a   = 1'b1;
    fp_done_a = with_fp_done;
    tick_a();
    start_a   = 1'b0;
    fp_done_a = 1'b0;
    chk("a_fp_start_hi", 64'(fp_start_a), 1);
    chk("a_sse_cleared", 64'(sse_a), 0);
    chk("a_rd_addr_cleared", 64'(rd_addr_a), 0);
  endtask

  task automatic finish_a(input int delay, input logic inj_wait, input logic inj_read,
                          output int lat);
    for (int i = 0; i < delay - 1; i++) begin
      start_a = inj_wait && (i == 2);
      tick_a();
    end
    start_a = 1'b0;
    chk("a_busy_in_wait", 64'(busy_a), 1);
    fp_done_a = 1'b1;
    tick_a();
    fp_done_a = 1'b0;
    chk("a_rd_en_after_fp_done", 64'(rd_en_a), 1);
    lat = 0;
    while (!done_a && lat < 50) begin
      start_a = inj_read && (lat == 1);
      tick_a();
      lat++;
    end
    start_a = 1'b0;
    chk("a_done", 64'(done_a), 1);
    chk("a_busy_low_at_done", 64'(busy_a), 0);
  endtask

  task automatic run_b(output int lat);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_fp_start_hi", 64'(fp_start_b), 1);
    chk("b_ovf_cleared", 64'(ovf_b), 0);
    repeat (3) @(negedge clk);
    fp_done_b = 1'b1;
    @(negedge clk);
    fp_done_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("b_latency", 64'(lat), B_ROWS + 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem_act_a[i] = '0; mem_pred_a[i] = '0;
      mem_act_b[i] = '0; mem_pred_b[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick_a();

    // Reset state
    chk("rst_fp_start", 64'(fp_start_a), 0);
    chk("rst_rd_en", 64'(rd_en_a), 0);
    chk("rst_rd_addr", 64'(rd_addr_a), 0);
    chk("rst_busy", 64'(busy_a), 0);
    chk("rst_done", 64'(done_a), 0);
    chk("rst_sse", 64'(sse_a), 0);
    chk("rst_ovf", 64'(ovf_a), 0);

    // Stray fp_done in IDLE
    fp_done_a = 1'b1;
    tick_a();
    fp_done_a = 1'b0;
    tick_a(); tick_a();
    chk("stray_fp_done_busy", 64'(busy_a), 0);
    chk("stray_fp_done_rd_en", 64'(rd_en_a), 0);
    chk("stray_fp_done_fp_start", 64'(fp_cnt_a), 0);

    // Basic pass: diffs 2,0,-4,0 -> 4+0+16+0 = 20
    set_a(0, 3, 1); set_a(1, 5, 5); set_a(2, 0, 4); set_a(3, -2, -2);
    fp_cnt_a = 0; addr_q.delete();
    start_pulse_a(1'b0);
    finish_a(10, 1'b0, 1'b0, n);
    chk("basic_latency", 64'(n), A_ROWS + 3);
    chk("basic_sse", 64'(sse_a), 20);
    chk("basic_ovf", 64'(ovf_a), 0);
    chk("basic_fp_start_cnt", 64'(fp_cnt_a), 1);

    // start pulsed in FP_WAIT and in READ is ignored
    fp_cnt_a = 0; addr_q.delete();
    start_pulse_a(1'b0);
    finish_a(10, 1'b1, 1'b1, n);
    chk("ign_start_fp_start_cnt", 64'(fp_cnt_a), 1);
    chk("ign_start_latency", 64'(n), A_ROWS + 3);
    chk("ign_start_sse", 64'(sse_a), 20);
    chk("ign_start_addr_cnt", 64'(addr_q.size()), A_ROWS);

    // Reset in READ at row 2
    start_pulse_a(1'b0);
    repeat (4) tick_a();
    fp_done_a = 1'b1;
    tick_a();
    fp_done_a = 1'b0;
    n = 0;
    while (!(rd_en_a && rd_addr_a == 3'd2) && n < 20) begin
      tick_a();
      n++;
    end
    chk("reset_reach_row2", 64'(n), 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_en", 64'(rd_en_a), 0);
    chk("midrst_rd_addr", 64'(rd_addr_a), 0);
    chk("midrst_busy", 64'(busy_a), 0);
    chk("midrst_done", 64'(done_a), 0);
    chk("midrst_fp_start", 64'(fp_start_a), 0);
    chk("midrst_sse", 64'(sse_a), 0);
    tick_a();
    rst_n = 1'b1;
    fp_done_a = 1'b1;
    tick_a();
    fp_done_a = 1'b0;
    tick_a();
    chk("late_fp_done_busy", 64'(busy_a), 0);
    chk("late_fp_done_rd_en", 64'(rd_en_a), 0);
    addr_q.delete();
    start_pulse_a(1'b0);
    finish_a(10, 1'b0, 1'b0, n);
    chk("post_rst_sse", 64'(sse_a), 20);
    chk("post_rst_latency", 64'(n), A_ROWS + 3);

    // Restart from DONE with start and fp_done together; all diffs 1 -> 4
    set_a(0, 1, 0); set_a(1, 2, 1); set_a(2, -3, -4); set_a(3, 100, 99);
    addr_q.delete();
    start_pulse_a(1'b1);
    finish_a(5, 1'b0, 1'b0, n);
    chk("restart_sse", 64'(sse_a), 4);
    chk("restart_ovf", 64'(ovf_a), 0);
    chk("restart_latency", 64'(n), A_ROWS + 3);
    chk("restart_addr_cnt", 64'(addr_q.size()), A_ROWS);
    for (int i = 0; i < addr_q.size() && i < A_ROWS; i++)
      chk($sformatf("restart_addr_%0d", i), 64'(addr_q[i]), 64'(i));

    // Saturation: 8 x 255^2 = 520200 > 2^18-1
    for (int i = 0; i < 8; i++) begin
      mem_act_b[i] = 8'sd127; mem_pred_b[i] = 8'h80;
    end
    run_b(n);
    chk("sat_sse", 64'(sse_b), 262143);
    chk("sat_ovf", 64'(ovf_b), 1);

    // Zero-error pass clears sticky overflow
    for (int i = 0; i < 8; i++) begin
      mem_act_b[i] = 8'd5; mem_pred_b[i] = 8'd5;
    end
    run_b(n);
    chk("zero_sse", 64'(sse_b), 0);
    chk("zero_ovf", 64'(ovf_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eval_ctrl.md
# eval_ctrl

Sequencer for the evaluation pass of the network. On `start` it launches one forward-propagation run, waits for its completion pulse, then walks the result and label memories row by row. It accumulates the sum of squared errors between label and prediction in a pipelined, saturating datapath, and presents the total with a done flag. It sits between the top-level test controller, `forward_propagation`, and the dual-read result/label RAM. It replaces the simulation-only post-pass accuracy loop with synthesizable hardware.

## Interface
- `ROWS`, 100: number of rows evaluated per pass (≥1).
- `ADDR_W`, 7: row address width; must satisfy 2^ADDR_W ≥ ROWS.
- `DATA_W`, 16: width of label and prediction words, signed two's complement.
- `ACC_W`, 40: accumulator width; must be ≥ 2*DATA_W+2.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a pass; sampled only in IDLE or DONE.
- `fp_start`  out  1  one-cycle launch pulse to forward propagation.
- `fp_done`  in  1  completion pulse from forward propagation.
- `rd_en`  out  1  read strobe to result/label RAM.
- `rd_addr`  out  ADDR_W  row address.
- `actual`  in  DATA_W  label word, valid the cycle after `rd_en`.
- `pred`  in  DATA_W  prediction word, valid the cycle after `rd_en`.
- `busy`  out  1  high in FP_LAUNCH, FP_WAIT, READ, DRAIN.
- `done`  out  1  high in DONE; `sse` is final.
- `sse`  out  ACC_W  sum of squared errors, unsigned.
- `overflow`  out  1  sticky; set if the accumulator saturated this pass.

## Operation
- FSM: IDLE → FP_LAUNCH → FP_WAIT → READ → DRAIN → DONE.
  - IDLE → FP_LAUNCH on `start`; clears `sse`, `overflow`, address counter.
  - FP_LAUNCH: `fp_start`=1 for exactly one cycle → FP_WAIT.
  - FP_WAIT → READ on `fp_done`.
  - READ: `rd_en`=1 every cycle, `rd_addr` = 0,1,…,ROWS-1. After the ROWS-1 cycle → DRAIN.
  - DRAIN: 3 cycles, counted internally, flush the pipeline → DONE.
  - DONE: hold `sse`/`done`; `start` behaves as from IDLE (restart clears the result).
- Datapath stages:
  - S1 registers `diff = actual - pred`, sign-extended to DATA_W+1.
  - S2 registers `diff*diff`, unsigned, 2*DATA_W+2 bits.
  - S3 adds into `sse`.
- Each stage carries a valid bit from `rd_en`, so only the ROWS real samples are accumulated.
- Saturation: if the sum exceeds 2^ACC_W-1, `sse` clamps to all-ones and `overflow` sets. `overflow` stays set until the next accepted `start` or reset.
- `start` outside IDLE/DONE is ignored, not queued.
- `fp_done` outside FP_WAIT is ignored.
- `fp_done` and `start` asserted in the same cycle while in DONE: `start` wins and the pass restarts.

## Timing
- Reset values: state IDLE; `fp_start`, `rd_en`, `busy`, `done`, `overflow` = 0; `rd_addr` = 0; `sse` = 0; all valid bits 0.
- `start` sampled at edge T gives `fp_start` high in cycle T+1 only.
- `fp_done` sampled at edge E:
  - `rd_en` is high for the ROWS cycles following edges E … E+ROWS-1.
  - The final `sse` update and the rise of `done` both occur at edge E+ROWS+3.
- `busy` and `done` are never high together; `busy` falls on the edge where `done` rises.
- Reset asserted mid-pass returns everything to reset values immediately and discards the partial sum. A late `fp_done` arriving after reset is ignored.
- `rd_addr` holds its last value when `rd_en` is low. It is 0 after reset and after an accepted `start`.

## Structure
- Package `eval_pkg` holds:
  - the state enum (IDLE, FP_LAUNCH, FP_WAIT, READ, DRAIN, DONE);
  - `DRAIN_CYCLES` = 3;
  - width helper functions for the square width.
- Sub-module `sq_err_pipe`: stages S1/S2 with valid propagation, parameterised on DATA_W. The FSM, address counter and saturating accumulator stay in `eval_ctrl`.

## Test plan
- Basic pass, ROWS=4: actual {3,5,0,-2}, pred {1,5,4,-2}, `fp_done` 10 cycles after `fp_start`.
  - Expect `sse`=20, `overflow`=0.
  - Expect `done` exactly ROWS+3 edges after the `fp_done` edge.
- Saturation, DATA_W=8, ACC_W=18, ROWS=8: all rows actual=127, pred=-128 (each square 65025, true sum 520200).
  - Expect `sse`=262143, `overflow`=1.
  - A following pass with zero error gives `sse`=0, `overflow`=0.
- `start` pulsed in FP_WAIT and in READ: no second `fp_start`, result unchanged. Stray `fp_done` in IDLE: stays IDLE.
- Reset asserted in READ at row 2:
  - Outputs go to reset values.
  - A new pass with identical data reproduces the basic-pass result of 20.
- Restart from DONE with different data (all diffs 1, ROWS=4): `sse` cleared on restart, final `sse`=4. `rd_addr` sequence is 0,1,2,3 with no gaps.
